// File: rtl/twdl_seq_cta_pkg.sv
// Shared FFT package: radix constants, sequencer state encoding, packed
// five-lane address type. The twiddle multiplier imports this package when
// it unpacks the address FIFO word.
package twdl_seq_cta_pkg;

  localparam int WADDR = 12;

  localparam logic [2:0] RDX2 = 3'd2;
  localparam logic [2:0] RDX3 = 3'd3;
  localparam logic [2:0] RDX4 = 3'd4;
  localparam logic [2:0] RDX5 = 3'd5;

  // Sequencer states
  typedef logic [1:0] seq_state_t;
  localparam seq_state_t ST_IDLE  = 2'd0;
  localparam seq_state_t ST_SETUP = 2'd1;
  localparam seq_state_t ST_RUN   = 2'd2;

  // Five data lanes; lane 0 occupies the MSBs when packed.
  typedef logic [0:4][WADDR-1:0] addr5_t;

  function automatic logic radix_legal(input logic [2:0] r);
    return (r >= RDX2) && (r <= RDX5);
  endfunction

endpackage

// File: rtl/twdl_seq_cta_stride_calc.sv
// Stride generator: s[m] = m*L for m=1..4 and r*L, built from shifts and
// adds only. Registered with one cycle of latency so the results are ready
// exactly when the sequencer leaves SETUP.
module stride_calc
  import twdl_seq_cta_pkg::*;
#(
  parameter int wAddr = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [2:0]       factor,
  input  logic [wAddr-1:0] len_l,
  output logic [wAddr-1:0] s1,
  output logic [wAddr-1:0] s2,
  output logic [wAddr-1:0] s3,
  output logic [wAddr-1:0] s4,
  output logic [wAddr-1:0] demontr
);

  logic [wAddr-1:0] l2;
  logic [wAddr-1:0] l3;
  logic [wAddr-1:0] l4;
  logic [wAddr-1:0] l5;
  logic [wAddr-1:0] dem_c;

  // Shift/add multiples of L and the radix-selected denominator r*L
  always_comb begin
    l2    = len_l << 1;
    l4    = len_l << 2;
    l3    = l2 + len_l;
    l5    = l4 + len_l;
    dem_c = l2;
    case (factor)
      RDX2:    dem_c = l2;
      RDX3:    dem_c = l3;
      RDX4:    dem_c = l4;
      RDX5:    dem_c = l5;
      default: dem_c = l2;
    endcase
  end

  // Capture strides while the sequencer sits in SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      s4      <= '0;
      demontr <= '0;
    end else if (load) begin
      s1      <= len_l;
      s2      <= l2;
      s3      <= l3;
      s4      <= l4;
      demontr <= dem_c;
    end
  end

endmodule

// File: rtl/twdl_seq_cta.sv
// Twiddle/address sequencer for one Cooley-Tukey stage. For each butterfly
// vector it issues the radix, twiddle numerator k and denominator r*L to the
// multiplier, the five data read addresses, and the same addresses into the
// write-back address FIFO.
//
// Handshake: out_val is the valid of a one-vector-per-cycle stream whose
// ready is ~stall. A vector is issued at a clock edge only when the
// sequencer is in RUN and stall was low in the cycle before that edge; the
// issued vector is visible (out_val=1) in the following cycle. There is no
// back-pressure on out_val itself: once visible it is consumed.
module twdl_seq_cta
  import twdl_seq_cta_pkg::*;
#(
  parameter int wAddr = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             factor,
  input  logic [wAddr-1:0]       len_l,
  input  logic [wAddr-1:0]       n_grp,
  input  logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic                   out_val,
  output logic [2:0]             factor_o,
  output logic [wAddr-1:0]       twdl_numrtr_1,
  output logic [wAddr-1:0]       twdl_demontr,
  output logic [0:4][wAddr-1:0]  rd_addr,
  output logic                   ff_addr_wrreq,
  output logic [5*wAddr-1:0]     ff_addr_data,
  output logic [1:0]             dbg_state
);

  localparam logic [wAddr-1:0] ONE = {{(wAddr-1){1'b0}}, 1'b1};

  seq_state_t            state;
  logic [2:0]            fac_q;
  logic [wAddr-1:0]      len_q;
  logic [wAddr-1:0]      grp_q;
  logic [wAddr-1:0]      k;
  logic [wAddr-1:0]      g;
  logic [wAddr-1:0]      base;

  logic [wAddr-1:0]      s1;
  logic [wAddr-1:0]      s2;
  logic [wAddr-1:0]      s3;
  logic [wAddr-1:0]      s4;
  logic [wAddr-1:0]      demontr;
  logic [0:4][wAddr-1:0] stride;
  logic [0:4][wAddr-1:0] lane;
  logic                  cfg_ok;
  logic                  k_wrap;
  logic                  last;

  assign dbg_state = state;
  assign stride    = {{wAddr{1'b0}}, s1, s2, s3, s4};

  stride_calc #(
    .wAddr(wAddr)
  ) u_stride (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state == ST_SETUP),
    .factor  (fac_q),
    .len_l   (len_q),
    .s1      (s1),
    .s2      (s2),
    .s3      (s3),
    .s4      (s4),
    .demontr (demontr)
  );

  // Config legality and end-of-group / end-of-stage detection
  always_comb begin
    cfg_ok = radix_legal(factor) && (len_l != '0) && (n_grp != '0);
    k_wrap = (k == len_q - ONE);
    last   = k_wrap && (g == grp_q - ONE);
  end

  // Lane addresses for the current vector; lanes beyond the radix read 0
  always_comb begin
    lane = '0;
    for (int m = 0; m < 5; m++) begin
      if (3'(m) < fac_q) begin
        lane[m] = base + k + stride[m];
      end
    end
  end

  // Sequencer FSM, counters and registered vector outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      fac_q         <= '0;
      len_q         <= '0;
      grp_q         <= '0;
      k             <= '0;
      g             <= '0;
      base          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      out_val       <= 1'b0;
      ff_addr_wrreq <= 1'b0;
      factor_o      <= '0;
      twdl_numrtr_1 <= '0;
      twdl_demontr  <= '0;
      rd_addr       <= '0;
      ff_addr_data  <= '0;
    end else begin
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      out_val       <= 1'b0;
      ff_addr_wrreq <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            if (cfg_ok) begin
              state <= ST_SETUP;
              fac_q <= factor;
              len_q <= len_l;
              grp_q <= n_grp;
              busy  <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          k     <= '0;
          g     <= '0;
          base  <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (!stall) begin
            out_val       <= 1'b1;
            ff_addr_wrreq <= 1'b1;
            factor_o      <= fac_q;
            twdl_numrtr_1 <= k;
            twdl_demontr  <= demontr;
            rd_addr       <= lane;
            ff_addr_data  <= lane;
            if (last) begin
              done  <= 1'b1;
              state <= ST_IDLE;
              k     <= '0;
              g     <= '0;
              base  <= '0;
            end else if (k_wrap) begin
              k    <= '0;
              g    <= g + ONE;
              base <= base + demontr;
            end else begin
              k <= k + ONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twdl_seq_cta.sv
// Directed bench for twdl_seq_cta: a per-stage vector model fills an
// expected queue, a negedge compare process checks every issued vector, and
// the directed tests pin latency, stall, config errors and reset abort.
module tb_twdl_seq_cta;
  import twdl_seq_cta_pkg::*;

  localparam int W  = 12;
  localparam int EW = 3 + W + W + 5 * W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [2:0]        factor;
  logic [W-1:0]      len_l;
  logic [W-1:0]      n_grp;
  logic              stall;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic              out_val;
  logic [2:0]        factor_o;
  logic [W-1:0]      twdl_numrtr_1;
  logic [W-1:0]      twdl_demontr;
  logic [0:4][W-1:0] rd_addr;
  logic              ff_addr_wrreq;
  logic [5*W-1:0]    ff_addr_data;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  int vec_cnt  = 0;
  int done_cnt = 0;
  int base_cnt;
  int dc0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cmp_e;

  twdl_seq_cta #(.wAddr(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .factor        (factor),
    .len_l         (len_l),
    .n_grp         (n_grp),
    .stall         (stall),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .out_val       (out_val),
    .factor_o      (factor_o),
    .twdl_numrtr_1 (twdl_numrtr_1),
    .twdl_demontr  (twdl_demontr),
    .rd_addr       (rd_addr),
    .ff_addr_wrreq (ff_addr_wrreq),
    .ff_addr_data  (ff_addr_data),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector (k, g) of a stage: {radix, k, r*L, lanes 0..4}
  function automatic logic [EW-1:0] model_vec(input int r, input int l, input int gi, input int ki);
    logic [0:4][W-1:0] a;
    a = '0;
    for (int m = 0; m < 5; m++) begin
      if (m < r) a[m] = W'((gi * r * l + ki + m * l) % 4096);
    end
    return {3'(r), W'(ki), W'(r * l), a};
  endfunction

  task automatic model_load(input int r, input int l, input int gcount);
    for (int gi = 0; gi < gcount; gi++)
      for (int ki = 0; ki < l; ki++)
        exp_q.push_back(model_vec(r, l, gi, ki));
  endtask

  // Driver: present config and pulse start across one edge
  task automatic drive(input int r, input int l, input int gcount);
    factor = 3'(r);
    len_l  = W'(l);
    n_grp  = W'(gcount);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk(name, done, 1);
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (ff_addr_wrreq !== out_val) begin
        failures++;
        $display("FAIL wrreq_eq_val actual=%0d required=%0d", ff_addr_wrreq, out_val);
      end
      if (done === 1'b1) done_cnt++;
      if (out_val === 1'b1) begin
        vec_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra_vector actual=%h required=none", rd_addr);
        end else begin
          cmp_e = exp_q.pop_front();
          if ({factor_o, twdl_numrtr_1, twdl_demontr, rd_addr} !== cmp_e) begin
            failures++;
            $display("FAIL sb_vector actual=%h required=%h",
                     {factor_o, twdl_numrtr_1, twdl_demontr, rd_addr}, cmp_e);
          end
          checks++;
          if (ff_addr_data !== cmp_e[5*W-1:0]) begin
            failures++;
            $display("FAIL sb_ff_data actual=%h required=%h", ff_addr_data, cmp_e[5*W-1:0]);
          end
          checks++;
          if (done !== (exp_q.size() == 0)) begin
            failures++;
            $display("FAIL sb_done actual=%0d required=%0d", done, exp_q.size() == 0);
          end
        end
      end else if (done === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL done_without_val actual=1 required=0");
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    rst_n  = 1'b1;
    start  = 1'b0;
    stall  = 1'b0;
    factor = 3'd2;
    len_l  = W'(1);
    n_grp  = W'(1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_wrreq", ff_addr_wrreq, 0);
    chk("rst_factor_o", factor_o, 0);
    chk("rst_numrtr", twdl_numrtr_1, 0);
    chk("rst_demontr", twdl_demontr, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_ff_data", ff_addr_data, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Radix-2, L=4, G=1
    model_load(2, 4, 1);
    drive(2, 4, 1);
    chk("r2_busy_after_start", busy, 1);
    chk("r2_val_e0", out_val, 0);
    tick();
    chk("r2_val_e1", out_val, 0);
    tick();
    chk("r2_val_first", out_val, 1);
    chk("r2_demontr", twdl_demontr, 8);
    chk("r2_v0_lane1", rd_addr[1], 4);
    chk("r2_v0_lane2", rd_addr[2], 0);
    tick(); tick(); tick();
    chk("r2_v3_done", done, 1);
    chk("r2_v3_num", twdl_numrtr_1, 3);
    chk("r2_v3_lane1", rd_addr[1], 7);
    chk("r2_v3_busy", busy, 1);
    tick();
    chk("r2_busy_drop", busy, 0);
    chk("r2_val_after", out_val, 0);

    // Radix-3, L=2, G=2
    model_load(3, 2, 2);
    drive(3, 2, 2);
    tick(); tick(); tick(); tick();
    chk("r3_v2_lane0", rd_addr[0], 6);
    chk("r3_v2_lane1", rd_addr[1], 8);
    chk("r3_v2_lane2", rd_addr[2], 10);
    chk("r3_v2_num", twdl_numrtr_1, 0);
    chk("r3_demontr", twdl_demontr, 6);
    wait_done(20, "r3_done_timeout");
    tick();
    chk("r3_busy_drop", busy, 0);

    // Radix-5 last stage, L=1, G=3
    model_load(5, 1, 3);
    drive(5, 1, 3);
    chk("r5_val_e0", out_val, 0);
    tick();
    chk("r5_val_e1", out_val, 0);
    tick();
    chk("r5_val_first", out_val, 1);
    chk("r5_demontr", twdl_demontr, 5);
    chk("r5_num", twdl_numrtr_1, 0);
    tick(); tick();
    chk("r5_v2_lane0", rd_addr[0], 10);
    chk("r5_v2_lane4", rd_addr[4], 14);
    chk("r5_v2_done", done, 1);
    tick();

    // Stall: r=4, L=3, G=1
    model_load(4, 3, 1);
    drive(4, 3, 1);
    tick(); tick();
    chk("st_val0", out_val, 1);
    stall = 1'b1;
    tick();
    chk("st_val1", out_val, 0);
    chk("st_hold_lane3", rd_addr[3], 9);
    tick();
    chk("st_val2", out_val, 0);
    stall = 1'b0;
    tick();
    chk("st_val3", out_val, 1);
    chk("st_v1_lane0", rd_addr[0], 1);
    chk("st_v1_lane1", rd_addr[1], 4);
    chk("st_v1_lane2", rd_addr[2], 7);
    chk("st_v1_lane3", rd_addr[3], 10);
    tick();
    chk("st_val4", out_val, 1);
    chk("st_done", done, 1);
    tick();

    // Illegal config
    drive(6, 3, 1);
    chk("bad_r_cfg_err", cfg_err, 1);
    chk("bad_r_busy", busy, 0);
    tick();
    chk("bad_r_cfg_err_clr", cfg_err, 0);
    chk("bad_r_busy2", busy, 0);
    chk("bad_r_val", out_val, 0);
    drive(3, 0, 2);
    chk("bad_l_cfg_err", cfg_err, 1);
    chk("bad_l_busy", busy, 0);
    tick();
    chk("bad_l_val", out_val, 0);
    drive(3, 2, 0);
    chk("bad_g_cfg_err", cfg_err, 1);
    tick();

    // Start while busy is ignored
    base_cnt = vec_cnt;
    model_load(2, 4, 2);
    drive(2, 4, 2);
    tick(); tick();
    factor = 3'd7;
    len_l  = W'(5);
    n_grp  = W'(5);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("busy_start_no_cfg_err", cfg_err, 0);
    wait_done(40, "ign_done_timeout");
    tick();
    chk("ign_vec_count", vec_cnt - base_cnt, 8);
    chk("ign_busy_drop", busy, 0);

    // Reset mid-run: r=2, L=8, G=2
    model_load(2, 8, 2);
    dc0 = done_cnt;
    drive(2, 8, 2);
    tick(); tick(); tick();
    chk("rr_v1_val", out_val, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_val", out_val, 0);
    chk("rr_busy", busy, 0);
    chk("rr_wrreq", ff_addr_wrreq, 0);
    chk("rr_rd_addr", rd_addr, 0);
    chk("rr_ff_data", ff_addr_data, 0);
    chk("rr_demontr", twdl_demontr, 0);
    chk("rr_factor_o", factor_o, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick();
    chk("rr_no_done", done_cnt - dc0, 0);
    base_cnt = vec_cnt;
    model_load(2, 8, 2);
    drive(2, 8, 2);
    wait_done(60, "rr_done_timeout");
    tick();
    chk("rr_full_count", vec_cnt - base_cnt, 16);
    chk("rr_busy_drop", busy, 0);

    tick();
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twdl_seq_cta.md
# twdl_seq_cta

Twiddle/address sequencer for one Cooley-Tukey (CTA) stage of the mixed-radix (2/3/4/5) FFT engine; the upstream counterpart of the twiddle multiplier.
- Per butterfly vector, drives the multiplier's `factor`, `twdl_numrtr_1` and `twdl_demontr` inputs.
- Produces the five data-memory read addresses for the vector.
- Pushes the same addresses into the address FIFO that the multiplier later pops with `rdreq_ff_addr` / `sclr_ff_addr`, for the write-back.

## Interface
Parameters:
- `wAddr`, 12: address and twiddle numerator/denominator width.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; samples config; ignored unless IDLE.
- `factor`  in  3  stage radix, legal 2..5.
- `len_l`  in  wAddr  butterflies per group L (stride), legal ≥1.
- `n_grp`  in  wAddr  group count G, legal ≥1.
- `stall`  in  1  hold issue this cycle (address FIFO almost full / downstream not ready).
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse, coincident with the last `out_val`.
- `cfg_err`  out  1  one-cycle pulse, the cycle after a `start` with illegal config.
- `out_val`  out  1  vector outputs valid.
- `factor_o`  out  3  latched radix.
- `twdl_numrtr_1`  out  wAddr  butterfly index k.
- `twdl_demontr`  out  wAddr  r·L.
- `rd_addr`  out  [0:4][wAddr-1:0]  data read addresses, lane m.
- `ff_addr_wrreq`  out  1  address FIFO write strobe, equals `out_val`.
- `ff_addr_data`  out  5·wAddr  `{rd_addr[0..4]}` packed, lane 0 in the MSBs.

## Operation
- FSM states: IDLE, SETUP, RUN.
  - IDLE→SETUP on `start` with legal config.
  - `start` with `factor`∉{2..5}, `len_l`==0 or `n_grp`==0: stay in IDLE, pulse `cfg_err`.
  - SETUP→RUN after exactly one cycle.
  - RUN→IDLE on the issue of the last vector.
- SETUP:
  - Latch r, L, G.
  - Compute strides s[m] = m·L for m=0..4 using shift/add only (no multiplier).
  - Compute demontr = r·L.
  - Clear k, g, base.
- RUN, each cycle with `stall`==0 issues one vector.
  - Lane address: addr[m] = base + k + s[m] for m<r.
  - Lanes m≥r drive 0.
  - Numerator = k; demontr held constant for the whole stage.
  - Counter update:
    - k<L−1: k++.
    - k==L−1: k=0, g++, base += demontr.
    - Last vector is k==L−1 and g==G−1.
- `stall`==1 in RUN: counters frozen, `out_val`=0, no FIFO write.
- Total issued vectors = L·G exactly; order is k fastest, g slowest.
- Arithmetic is unsigned, modulo 2^wAddr. A product r·L·G > 2^wAddr wraps silently; configuring within range is the caller's duty.
- `start` while busy: ignored, no `cfg_err`.
- `stall` in IDLE/SETUP: no effect.
- L==1 (last stage): numerator is always 0 and demontr==r. This is the multiplier's bypass case when r==3.

## Timing
- Reset (asynchronous): state IDLE. Reset values:
  - `busy`, `done`, `cfg_err`, `out_val`, `ff_addr_wrreq`: 0.
  - `factor_o`, `twdl_numrtr_1`, `twdl_demontr`, all `rd_addr`, `ff_addr_data`: 0.
  - Counters: 0.
- Reset mid-RUN aborts immediately. There are no further writes, and no `done` pulse.
- All outputs are registered. A vector issued at edge E appears in the cycle after E.
- `start` sampled at edge E0 → SETUP during E0..E1 → first issue at E2.
- Without stall: first `out_val` follows E2, so `out_val` first appears 2 cycles after the start edge. Vectors are then back-to-back, one per cycle.
- The last vector's `out_val` and `done` are high in the same cycle. `busy` drops the following cycle.
- A new `start` is accepted in that following cycle.
- `stall` asserted in cycle c suppresses the issue at the next edge. Output fields hold their last values and `out_val` is 0.

## Structure
- Shared FFT package holds:
  - the radix constants (`RDX2`..`RDX5`);
  - the FSM state enum;
  - the packed-address type `addr5_t` ([0:4][wAddr-1:0]).
  - The twiddle multiplier reuses the package when unpacking the FIFO word.
- One sub-module, `stride_calc`: shift/add generation of s[1..4] and r·L. Registered, one-cycle latency, matched to SETUP.

## Test plan
- **Radix-2:** r=2, L=4, G=1 → 4 vectors.
  - Numerator 0,1,2,3; demontr 8.
  - Addresses (0,4),(1,5),(2,6),(3,7); lanes 2–4 are 0.
  - `done` coincides with the 4th `out_val`.
- **Radix-3:** r=3, L=2, G=2.
  - Addresses (0,2,4),(1,3,5),(6,8,10),(7,9,11).
  - Numerator 0,1,0,1; demontr 6.
  - `ff_addr_data` matches `rd_addr` on every write.
- **Radix-5, last stage:** r=5, L=1, G=3.
  - Numerator always 0; demontr 5.
  - Addresses 0–4, 5–9, 10–14.
  - First `out_val` 2 cycles after `start`.
- **Stall:** r=4, L=3, G=1, `stall` high for 2 cycles after the first vector.
  - `out_val` pattern 1,0,0,1,1.
  - Addresses continue 1,4,7,10 with no skip or duplicate.
- **Illegal config and ignored start:**
  - `start` with r=6 → `cfg_err` pulse, `busy` stays 0.
  - `start` with L=0 → same.
  - Second `start` during RUN is ignored; the vector count is unchanged.
- **Reset mid-run:**
  - Assert `rst_n`=0 asynchronously at vector 2 of r=2, L=8, G=2.
  - All outputs go to 0 immediately; no `done`.
  - After release, a fresh `start` runs the full 16 vectors.
